// File: rtl/pi_spi_link_pkg.sv
// Shared constants and FSM encoding for the Raspberry Pi SPI link.
package pi_spi_link_pkg;

  localparam int         DEF_WORD_W    = 8;
  localparam logic [7:0] DEF_IDLE_WORD = 8'h00;
  localparam int         SYNC_STAGES   = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } link_state_e;

endpackage

// File: rtl/pi_spi_link_fifo.sv
// Small synchronous FIFO used for both link directions; pointers carry one extra wrap bit.
module pi_spi_link_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];
  assign w_do_pop  = i_pop & ~o_empty;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/pi_spi_link.sv
// SPI mode-0 slave for the Raspberry Pi link: synchronises the Pi pins, assembles words
// into an RX FIFO and serialises TX FIFO words (or IDLE_WORD when empty) onto miso.
module pi_spi_link
  import pi_spi_link_pkg::*;
#(
  parameter int                WORD_W     = DEF_WORD_W,
  parameter int                RX_DEPTH   = 4,
  parameter int                TX_DEPTH   = 4,
  parameter int                CS_ACT_LOW = 1,
  parameter logic [WORD_W-1:0] IDLE_WORD  = WORD_W'(DEF_IDLE_WORD)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_spi_sclk,
  input  logic              i_spi_cs,
  input  logic              i_spi_mosi,
  output logic              o_spi_miso,
  output logic              o_out_req,
  output logic [WORD_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  input  logic              i_rx_ready,
  input  logic [WORD_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic              o_rx_overflow,
  output logic              o_frame_err,
  output logic              o_dbg_state
);

  // Handshakes: a word moves on a clock edge where valid & ready are both high; valid
  // never depends on ready, and rx_data/tx_data must be stable while valid is high.

  localparam int                CNT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  logic [SYNC_STAGES:0]   r_sclk_sh;
  logic [SYNC_STAGES:0]   r_cs_sh;
  logic [SYNC_STAGES-1:0] r_mosi_sh;
  logic                   r_armed;
  link_state_e            r_state;
  link_state_e            w_next_state;
  logic [WORD_W-1:0]      r_tx_shreg;
  logic [WORD_W-1:0]      r_rx_shreg;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_out_req;
  logic                   r_rx_overflow;
  logic                   r_frame_err;

  logic              w_sclk_rise;
  logic              w_sclk_fall;
  logic              w_cs_act;
  logic              w_mosi;
  logic              w_start;
  logic              w_load;
  logic              w_shift_tx;
  logic              w_rx_shift;
  logic              w_word_done;
  logic              w_cs_drop;
  logic              w_frame_err;
  logic              w_tx_pop;
  logic              w_tx_push;
  logic              w_tx_empty;
  logic              w_tx_full;
  logic [WORD_W-1:0] w_tx_head;
  logic              w_rx_pop;
  logic              w_rx_push;
  logic              w_rx_can_push;
  logic              w_rx_empty;
  logic              w_rx_full;
  logic              w_overflow;
  logic [WORD_W-1:0] w_rx_word;

  assign w_sclk_rise = r_sclk_sh[SYNC_STAGES-1] & ~r_sclk_sh[SYNC_STAGES];
  assign w_sclk_fall = ~r_sclk_sh[SYNC_STAGES-1] & r_sclk_sh[SYNC_STAGES];
  assign w_cs_act    = (CS_ACT_LOW != 0) ? ~r_cs_sh[SYNC_STAGES-1] : r_cs_sh[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sh[SYNC_STAGES-1];
  // A chip select that was already active when reset released must be seen idle first.
  assign w_start     = r_armed & w_cs_act;
  assign w_rx_word   = {r_rx_shreg[WORD_W-2:0], w_mosi};

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // FSM next state
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_start)   w_next_state = ST_ACTIVE;
      ST_ACTIVE: if (!w_cs_act) w_next_state = ST_IDLE;
      default:                  w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: per-cycle datapath strobes
  always_comb begin
    w_load      = 1'b0;
    w_shift_tx  = 1'b0;
    w_rx_shift  = 1'b0;
    w_word_done = 1'b0;
    w_cs_drop   = 1'b0;
    w_frame_err = 1'b0;
    unique case (r_state)
      ST_IDLE: w_load = w_start;
      ST_ACTIVE: begin
        if (!w_cs_act) begin
          w_cs_drop   = 1'b1;
          w_frame_err = (r_bit_cnt != '0);
        end else begin
          if (w_sclk_rise) begin
            w_rx_shift  = 1'b1;
            w_word_done = (r_bit_cnt == LAST_BIT);
          end
          if (w_sclk_fall) begin
            if (r_bit_cnt != '0) w_shift_tx = 1'b1;
            else                 w_load     = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign w_tx_pop      = w_load & ~w_tx_empty;
  assign w_tx_push     = i_tx_valid & o_tx_ready;
  assign w_rx_pop      = o_rx_valid & i_rx_ready;
  assign w_rx_can_push = ~w_rx_full | w_rx_pop;
  assign w_rx_push     = w_word_done & w_rx_can_push;
  assign w_overflow    = w_word_done & ~w_rx_can_push;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sclk_sh     <= '0;
      r_cs_sh       <= '0;
      r_mosi_sh     <= '0;
      r_armed       <= 1'b0;
      r_tx_shreg    <= '0;
      r_rx_shreg    <= '0;
      r_bit_cnt     <= '0;
      r_out_req     <= 1'b0;
      r_rx_overflow <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_sclk_sh     <= {r_sclk_sh[SYNC_STAGES-1:0], i_spi_sclk};
      r_cs_sh       <= {r_cs_sh[SYNC_STAGES-1:0], i_spi_cs};
      r_mosi_sh     <= {r_mosi_sh[SYNC_STAGES-2:0], i_spi_mosi};
      r_armed       <= r_armed | ~w_cs_act;
      r_out_req     <= ~w_tx_empty;
      r_rx_overflow <= w_overflow;
      r_frame_err   <= w_frame_err;
      if (w_load) begin
        r_tx_shreg <= w_tx_empty ? IDLE_WORD : w_tx_head;
        r_bit_cnt  <= '0;
      end else if (w_shift_tx) begin
        r_tx_shreg <= {r_tx_shreg[WORD_W-2:0], 1'b0};
      end
      if (w_rx_shift) begin
        r_rx_shreg <= w_rx_word;
        r_bit_cnt  <= w_word_done ? '0 : r_bit_cnt + 1'b1;
      end
      if (w_cs_drop) r_bit_cnt <= '0;
    end
  end

  pi_spi_link_fifo #(.WIDTH(WORD_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_rx_push),
    .i_wdata (w_rx_word),
    .i_pop   (w_rx_pop),
    .o_rdata (o_rx_data),
    .o_empty (w_rx_empty),
    .o_full  (w_rx_full)
  );

  pi_spi_link_fifo #(.WIDTH(WORD_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_tx_push),
    .i_wdata (i_tx_data),
    .i_pop   (w_tx_pop),
    .o_rdata (w_tx_head),
    .o_empty (w_tx_empty),
    .o_full  (w_tx_full)
  );

  assign o_rx_valid    = ~w_rx_empty;
  assign o_tx_ready    = ~w_tx_full | w_tx_pop;
  assign o_out_req     = r_out_req;
  assign o_rx_overflow = r_rx_overflow;
  assign o_frame_err   = r_frame_err;
  assign o_spi_miso    = (r_state == ST_ACTIVE) & r_tx_shreg[WORD_W-1];
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_pi_spi_link.sv
// Bench for pi_spi_link: a Pi-side SPI master model, queue-based TX/RX reference model
// and a monitor that scores every RX word and counts error pulses.
module tb_pi_spi_link;

  localparam int         W      = 8;
  localparam int         RXD    = 4;
  localparam int         TXD    = 4;
  localparam int         HP     = 10;
  localparam logic [7:0] IDLE_W = 8'h00;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sclk = 1'b0;
  logic         cs = 1'b1;
  logic         mosi = 1'b0;
  logic         miso;
  logic         out_req;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic         rx_overflow;
  logic         frame_err;
  logic         dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] tx_model[$];
  logic [W-1:0] cur_miso_exp;
  int           rx_occ = 0;
  int           exp_ovf = 0;
  int           exp_ferr = 0;
  int           ovf_cnt = 0;
  int           ferr_cnt = 0;
  bit           rand_ready = 1'b0;
  bit           partial = 1'b0;

  // clock / reset block
  always #5 clk = ~clk;

  pi_spi_link dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_spi_sclk    (sclk),
    .i_spi_cs      (cs),
    .i_spi_mosi    (mosi),
    .o_spi_miso    (miso),
    .o_out_req     (out_req),
    .o_rx_data     (rx_data),
    .o_rx_valid    (rx_valid),
    .i_rx_ready    (rx_ready),
    .i_tx_data     (tx_data),
    .i_tx_valid    (tx_valid),
    .o_tx_ready    (tx_ready),
    .o_rx_overflow (rx_overflow),
    .o_frame_err   (frame_err),
    .o_dbg_state   (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          check("rx_unexpected_word", rx_data, 32'hFFFF_FFFF);
        end else begin
          check("rx_data", rx_data, exp_q.pop_front());
          rx_occ--;
        end
      end
      if (rx_overflow) ovf_cnt++;
      if (frame_err) ferr_cnt++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
    end
  end

  // driver tasks
  task automatic tx_push(input logic [W-1:0] v);
    bit acc = 1'b0;
    @(negedge clk);
    tx_data  = v;
    tx_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (tx_ready) acc = 1'b1;
      @(negedge clk);
      if (acc) break;
    end
    tx_valid = 1'b0;
    check("tx_push_accepted", acc, 1);
    if (acc) tx_model.push_back(v);
  endtask

  task automatic pi_bit(input logic b, output logic got);
    mosi = b;
    repeat (HP) @(negedge clk);
    got  = miso;
    sclk = 1'b1;
    repeat (HP) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic pi_begin();
    cs = 1'b0;
    cur_miso_exp = (tx_model.size() != 0) ? tx_model.pop_front() : IDLE_W;
    repeat (HP) @(negedge clk);
    check("fsm_active", dbg_state, 1);
  endtask

  task automatic pi_word(input logic [W-1:0] w, input int push_at, input logic [W-1:0] push_v);
    logic [W-1:0] got = '0;
    logic         b;
    for (int i = 0; i < W; i++) begin
      if (i == push_at) tx_push(push_v);
      if (i == W - 1) begin
        if (rx_occ < RXD) begin
          exp_q.push_back(w);
          rx_occ++;
        end else begin
          exp_ovf++;
        end
      end
      pi_bit(w[W-1-i], b);
      got = {got[W-2:0], b};
    end
    check("miso_word", got, cur_miso_exp);
    cur_miso_exp = (tx_model.size() != 0) ? tx_model.pop_front() : IDLE_W;
  endtask

  task automatic pi_partial(input logic [W-1:0] w, input int n);
    logic b;
    for (int i = 0; i < n; i++) pi_bit(w[W-1-i], b);
    partial = 1'b1;
  endtask

  task automatic pi_end();
    repeat (HP) @(negedge clk);
    cs = 1'b1;
    if (partial) exp_ferr++;
    partial = 1'b0;
    repeat (2 * HP) @(negedge clk);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 500 && exp_q.size() != 0; k++) @(negedge clk);
    check("rx_drain", exp_q.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_tx_ready"}, tx_ready, 1);
    check({tag, "_out_req"}, out_req, 0);
    check({tag, "_miso"}, miso, 0);
    check({tag, "_overflow"}, rx_overflow, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] got;
    logic         b;

    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("rst");
    rx_ready = 1'b1;

    // single word 0xA5
    pi_begin();
    pi_word(8'hA5, -1, '0);
    pi_end();
    wait_drain();
    check("t1_overflow_cnt", ovf_cnt, exp_ovf);
    check("t1_frame_cnt", ferr_cnt, exp_ferr);

    // TX word 0x3C and out_req
    tx_push(8'h3C);
    repeat (2) @(negedge clk);
    check("t2_out_req_set", out_req, 1);
    pi_begin();
    pi_word(W'($urandom), -1, '0);
    pi_end();
    check("t2_out_req_clear", out_req, 0);
    wait_drain();

    // RX overflow with five words and no consumer
    rx_ready = 1'b0;
    pi_begin();
    for (int i = 0; i < 5; i++) pi_word(W'($urandom), -1, '0);
    pi_end();
    check("t3_rx_valid_held", rx_valid, 1);
    check("t3_overflow_cnt", ovf_cnt, exp_ovf);
    check("t3_overflow_exp", exp_ovf, 1);
    rx_ready = 1'b1;
    wait_drain();

    // frame error after 3 bits, then a clean word
    pi_begin();
    pi_partial(W'($urandom), 3);
    pi_end();
    check("t4_frame_cnt", ferr_cnt, exp_ferr);
    check("t4_rx_valid", rx_valid, 0);
    pi_begin();
    pi_word(W'($urandom), -1, '0);
    pi_end();
    wait_drain();
    check("t4_frame_cnt_after", ferr_cnt, exp_ferr);

    // idle words in a burst, push mid-word lands in word 2
    pi_begin();
    pi_word(W'($urandom), 4, 8'h81);
    pi_word(W'($urandom), -1, '0);
    pi_end();
    wait_drain();

    // reset mid-word with cs held low
    pi_begin();
    pi_partial(W'($urandom), 4);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    partial = 1'b0;
    tx_model.delete();
    @(negedge clk);
    check_reset_state("mid_rst");
    got = '0;
    for (int i = 0; i < W; i++) begin
      pi_bit(1'($urandom), b);
      got = {got[W-2:0], b};
    end
    check("t6_miso_ignored", got, 0);
    check("t6_state_idle", dbg_state, 0);
    repeat (HP) @(negedge clk);
    cs = 1'b1;
    repeat (2 * HP) @(negedge clk);
    check("t6_rx_valid", rx_valid, 0);
    check("t6_frame_cnt", ferr_cnt, exp_ferr);
    pi_begin();
    pi_word(8'h5A, -1, '0);
    pi_end();
    wait_drain();

    // randomized bursts
    rand_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      int npush = $urandom_range(0, 2);
      int nw    = $urandom_range(1, 3);
      for (int p = 0; p < npush; p++) begin
        if (tx_model.size() < TXD) tx_push(W'($urandom));
      end
      pi_begin();
      for (int k = 0; k < nw; k++) pi_word(W'($urandom), -1, '0);
      if ($urandom_range(0, 3) == 0) pi_partial(W'($urandom), $urandom_range(1, W - 1));
      pi_end();
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1 rx_ready = 1'b1;
    wait_drain();
    check("final_overflow_cnt", ovf_cnt, exp_ovf);
    check("final_frame_cnt", ferr_cnt, exp_ferr);
    check("final_out_req", out_req, (tx_model.size() != 0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
